// File: rtl/homomorphic_decrypt.sv
// LWE decryption core.
// The block takes the ciphertext body b at start, then one (a_i, s_i) beat
// per transfer, and accumulates sum(a_i*s_i) mod q. It then rounds (b - acc) mod q
// down to the plaintext m mod p.
// Handshakes: a transfer happens on a rising edge only when valid && ready are
// both high. The producer holds its data stable while valid is high and ready
// is low. in_ready is high only while beats are being collected. out_valid and
// plaintext stay stable until out_ready is seen.
module homomorphic_decrypt #(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 21,
    parameter int DIMENSION          = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [CIPHERTEXT_WIDTH-1:0] b_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CIPHERTEXT_WIDTH-1:0] a_in,
    input  logic [CIPHERTEXT_WIDTH-1:0] s_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PLAINTEXT_WIDTH-1:0]  plaintext,
    output logic                        busy,
    output logic [1:0]                  dbg_state
);

    localparam int CW    = CIPHERTEXT_WIDTH;
    localparam int PW    = PLAINTEXT_WIDTH;
    localparam int SHIFT = $clog2(CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS);
    localparam int CNTW  = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;

    // q is a power of two, so "mod q" is a mask of the low log2(q) bits.
    localparam logic [CW-1:0]   Q_MASK    = CW'(CIPHERTEXT_MODULUS - 1);
    localparam logic [CW:0]     HALF_STEP = (CW+1)'(CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS));
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(DIMENSION - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   b_q;
    logic [CW-1:0]   acc_q;
    logic [CNTW-1:0] cnt_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [PW-1:0]   pt_q;

    logic [2*CW-1:0] prod_w;
    logic [CW-1:0]   acc_d;
    logic [CW-1:0]   x_w;
    logic [CW:0]     rnd_w;
    logic [PW-1:0]   m_d;
    logic            beat_w;

    // Datapath: full-width product, modular accumulate, then centre-rounding to m.
    always_comb begin
        prod_w = {{CW{1'b0}}, a_in & Q_MASK} * {{CW{1'b0}}, s_in & Q_MASK};
        acc_d  = CW'(({{CW{1'b0}}, acc_q} + prod_w) & {{CW{1'b0}}, Q_MASK});
        x_w    = (b_q - acc_q) & Q_MASK;
        rnd_w  = {1'b0, x_w} + HALF_STEP;
        m_d    = PW'(rnd_w >> SHIFT);
        beat_w = in_valid && in_ready_q;
    end

    // Control FSM with registered handshake/status outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            pt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        b_q        <= b_in & Q_MASK;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (beat_w) begin
                        acc_q <= acc_d;
                        if (cnt_q == LAST_BEAT) begin
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= FINISH;
                        end else begin
                            cnt_q <= cnt_q + CNTW'(1);
                        end
                    end
                end
                FINISH: begin
                    pt_q        <= m_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign plaintext = pt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_homomorphic_decrypt.sv
// Bench for homomorphic_decrypt: one instance with n=1 (index 0) and one with
// n=4 (index 1). Known vectors come from a table and random ones from a reference model.
module tb_homomorphic_decrypt;

    localparam int P  = 64;
    localparam int PW = 6;
    localparam int Q  = 1024;
    localparam int CW = 21;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          start_v [2];
    logic [CW-1:0] b_v     [2];
    logic [CW-1:0] a_v     [2];
    logic [CW-1:0] s_v     [2];
    logic          iv_v    [2];
    logic          ordy_v  [2];

    logic          ir0, ov0, busy0, ir1, ov1, busy1;
    logic [PW-1:0] pt0, pt1;
    logic [1:0]    st0, st1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    homomorphic_decrypt #(.DIMENSION(1)) dut_n1 (
        .clk(clk), .rst_n(rst), .start(start_v[0]), .b_in(b_v[0]),
        .in_valid(iv_v[0]), .in_ready(ir0), .a_in(a_v[0]), .s_in(s_v[0]),
        .out_valid(ov0), .out_ready(ordy_v[0]), .plaintext(pt0),
        .busy(busy0), .dbg_state(st0)
    );

    homomorphic_decrypt #(.DIMENSION(4)) dut_n4 (
        .clk(clk), .rst_n(rst), .start(start_v[1]), .b_in(b_v[1]),
        .in_valid(iv_v[1]), .in_ready(ir1), .a_in(a_v[1]), .s_in(s_v[1]),
        .out_valid(ov1), .out_ready(ordy_v[1]), .plaintext(pt1),
        .busy(busy1), .dbg_state(st1)
    );

    function automatic logic get_ir(input int u);
        return (u == 1) ? ir1 : ir0;
    endfunction
    function automatic logic get_ov(input int u);
        return (u == 1) ? ov1 : ov0;
    endfunction
    function automatic logic get_busy(input int u);
        return (u == 1) ? busy1 : busy0;
    endfunction
    function automatic logic [PW-1:0] get_pt(input int u);
        return (u == 1) ? pt1 : pt0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer LWE decryption with division-based rounding.
    function automatic int ref_plain(input longint b, input longint a[4], input longint s[4], input int n);
        longint acc = 0;
        longint x;
        for (int i = 0; i < n; i++) acc = (acc + (a[i] % Q) * (s[i] % Q)) % Q;
        x = ((b % Q) - acc + Q) % Q;
        return int'(((x + Q / (2 * P)) / (Q / P)) % P);
    endfunction

    typedef struct {
        int     u;
        longint b;
        longint a[4];
        longint s[4];
        int     gap_at;
        int     gap_len;
        int     exp_m;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input int u, input longint b,
                           input longint a0, input longint s0, input longint a1, input longint s1,
                           input longint a2, input longint s2, input longint a3, input longint s3,
                           input int gap_at, input int gap_len, input int exp_m);
        vec_t v;
        v.u = u; v.b = b;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
        v.gap_at = gap_at; v.gap_len = gap_len; v.exp_m = exp_m;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full decryption: start, beats (optional in_valid gap), wait, handshake.
    task automatic run_dec(input int u, input longint b, input longint a[4], input longint s[4],
                           input int gap_at, input int gap_len, input int exp_m, input string tag);
        int n;
        int edges;
        int waited;
        n = (u == 1) ? 4 : 1;
        start_v[u] = 1'b1;
        b_v[u]     = CW'(b);
        tick();
        edges = 1;
        start_v[u] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k == gap_at && gap_len > 0) begin
                iv_v[u] = 1'b0;
                a_v[u]  = CW'($urandom);
                s_v[u]  = CW'($urandom);
                repeat (gap_len) tick();
                edges += gap_len;
            end
            check({tag, "_in_ready"}, 32'(get_ir(u)), 32'd1);
            iv_v[u] = 1'b1;
            a_v[u]  = CW'(a[k]);
            s_v[u]  = CW'(s[k]);
            tick();
            edges++;
        end
        iv_v[u] = 1'b0;
        waited = 0;
        while (!get_ov(u) && waited < 20) begin
            tick();
            edges++;
            waited++;
        end
        check({tag, "_out_valid"}, 32'(get_ov(u)), 32'd1);
        check({tag, "_plaintext"}, 32'(get_pt(u)), 32'(exp_m));
        check({tag, "_latency"}, 32'(edges),
              32'(n + 2 + ((gap_at >= 0 && gap_at < n) ? gap_len : 0)));
        ordy_v[u] = 1'b1;
        tick();
        ordy_v[u] = 1'b0;
        check({tag, "_ov_cleared"}, 32'(get_ov(u)), 32'd0);
        check({tag, "_idle"}, 32'(get_busy(u)), 32'd0);
        check({tag, "_pt_hold"}, 32'(get_pt(u)), 32'(exp_m));
    endtask

    initial begin
        longint ra[4];
        longint rs[4];
        longint rb;
        int     ru;
        int     ga;
        int     gl;

        for (int u = 0; u < 2; u++) begin
            start_v[u] = 1'b0; b_v[u] = '0; a_v[u] = '0; s_v[u] = '0;
            iv_v[u] = 1'b0; ordy_v[u] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        for (int u = 0; u < 2; u++) begin
            check("rst_in_ready", 32'(get_ir(u)), 32'd0);
            check("rst_out_valid", 32'(get_ov(u)), 32'd0);
            check("rst_busy", 32'(get_busy(u)), 32'd0);
            check("rst_plaintext", 32'(get_pt(u)), 32'd0);
        end
        rst = 1'b0;
        tick();

        // Known vectors
        add_vec(0, 458, 0, 7, 0, 0, 0, 0, 0, 0, -1, 0, 29);
        add_vec(0, 102, 3, 5, 0, 0, 0, 0, 0, 0, -1, 0, 5);
        add_vec(0, 10, 1, 14, 0, 0, 0, 0, 0, 0, -1, 0, 0);
        add_vec(0, 10, 1, 20, 0, 0, 0, 0, 0, 0, -1, 0, 63);
        add_vec(1, 1000, 100, 1, 200, 2, 300, 3, 400, 4, 2, 2, 3);
        add_vec(1, 1000, 100, 1, 200, 2, 300, 3, 400, 4, -1, 0, 3);
        // Inputs above q must be reduced: 1024+458, a=1024, s=1024+7.
        add_vec(0, 1482, 1024, 1031, 0, 0, 0, 0, 0, 0, -1, 0, 29);
        for (int i = 0; i < vq.size(); i++)
            run_dec(vq[i].u, vq[i].b, vq[i].a, vq[i].s, vq[i].gap_at, vq[i].gap_len,
                    vq[i].exp_m, $sformatf("vec%0d", i));

        // Start and in_valid together in IDLE: the beat must not be taken.
        start_v[0] = 1'b1; b_v[0] = CW'(102);
        iv_v[0] = 1'b1; a_v[0] = CW'(1); s_v[0] = CW'(14);
        tick();
        start_v[0] = 1'b0; iv_v[0] = 1'b0;
        check("simul_in_ready", 32'(ir0), 32'd1);
        check("simul_no_out", 32'(ov0), 32'd0);
        iv_v[0] = 1'b1; a_v[0] = CW'(3); s_v[0] = CW'(5);
        tick();
        iv_v[0] = 1'b0;
        tick();
        check("simul_out_valid", 32'(ov0), 32'd1);
        check("simul_plaintext", 32'(pt0), 32'd5);
        ordy_v[0] = 1'b1; tick(); ordy_v[0] = 1'b0;

        // Backpressure in OUT with a stray start pulse.
        start_v[0] = 1'b1; b_v[0] = CW'(458);
        tick();
        start_v[0] = 1'b0;
        iv_v[0] = 1'b1; a_v[0] = '0; s_v[0] = CW'(7);
        tick();
        iv_v[0] = 1'b0;
        tick();
        check("bp_first_valid", 32'(ov0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            start_v[0] = (i == 2);
            b_v[0] = CW'(10);
            tick();
            check("bp_hold_valid", 32'(ov0), 32'd1);
            check("bp_hold_pt", 32'(pt0), 32'd29);
            check("bp_hold_in_ready", 32'(ir0), 32'd0);
        end
        start_v[0] = 1'b0;
        ordy_v[0] = 1'b1;
        tick();
        ordy_v[0] = 1'b0;
        check("bp_release_valid", 32'(ov0), 32'd0);
        check("bp_release_busy", 32'(busy0), 32'd0);
        tick();
        check("bp_start_ignored", 32'(busy0), 32'd0);

        // Random stimulus against the reference model.
        for (int r = 0; r < 24; r++) begin
            ru = r % 2;
            rb = longint'($urandom_range(0, (1 << CW) - 1));
            for (int k = 0; k < 4; k++) begin
                ra[k] = longint'($urandom_range(0, (1 << CW) - 1));
                rs[k] = longint'($urandom_range(0, (1 << CW) - 1));
            end
            ga = (ru == 1) ? int'($urandom_range(0, 3)) : 0;
            gl = int'($urandom_range(0, 2));
            run_dec(ru, rb, ra, rs, ga, gl, ref_plain(rb, ra, rs, (ru == 1) ? 4 : 1),
                    $sformatf("rnd%0d", r));
        end

        // Reset while in OUT (n=1): result discarded.
        start_v[0] = 1'b1; b_v[0] = CW'(458);
        tick();
        start_v[0] = 1'b0;
        iv_v[0] = 1'b1; a_v[0] = '0; s_v[0] = CW'(7);
        tick();
        iv_v[0] = 1'b0;
        tick();
        check("rout_valid_before", 32'(ov0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rout_valid", 32'(ov0), 32'd0);
        check("rout_plaintext", 32'(pt0), 32'd0);
        check("rout_busy", 32'(busy0), 32'd0);

        // Reset mid-LOAD (n=4) after one beat, then a clean decryption.
        run_dec(1, 1000, vq[5].a, vq[5].s, -1, 0, 3, "pre_abort");
        start_v[1] = 1'b1; b_v[1] = CW'(1000);
        tick();
        start_v[1] = 1'b0;
        iv_v[1] = 1'b1; a_v[1] = CW'(100); s_v[1] = CW'(1);
        tick();
        a_v[1] = CW'(200); s_v[1] = CW'(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        iv_v[1] = 1'b0;
        check("abort_in_ready", 32'(ir1), 32'd0);
        check("abort_out_valid", 32'(ov1), 32'd0);
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_plaintext", 32'(pt1), 32'd0);
        tick();
        run_dec(1, 1000, vq[4].a, vq[4].s, 2, 2, 3, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/homomorphic_decrypt.md
HOMOMORPHIC_DECRYPT -- requirements
Module: homomorphic_decrypt

Interface
REQ-001 SHALL have parameter PLAINTEXT_MODULUS, default 64: plaintext modulus p; power of two.
REQ-002 SHALL have parameter PLAINTEXT_WIDTH, default 6: log2(p).
REQ-003 SHALL have parameter CIPHERTEXT_MODULUS, default 1024: ciphertext modulus q; power of two; q > p.
REQ-004 SHALL have parameter CIPHERTEXT_WIDTH, default 21: element bus width; at least log2(q).
REQ-005 SHALL have parameter DIMENSION, default 1: LWE dimension n, where n >= 1.
REQ-006 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-007 SHALL have port rst_n  input  1: synchronous active-high reset (asserted when 1).
REQ-008 SHALL have port start  input  1: pulse that begins a decryption; b_in is sampled on the same edge.
REQ-009 SHALL have port b_in  input  CIPHERTEXT_WIDTH: ciphertext body b.
REQ-010 SHALL have port in_valid  input  1: the a_in/s_in beat is valid.
REQ-011 SHALL have port in_ready  output  1: block accepts a beat.
REQ-012 SHALL have port a_in  input  CIPHERTEXT_WIDTH: ciphertext mask element a_i.
REQ-013 SHALL have port s_in  input  CIPHERTEXT_WIDTH: secret-key element s_i.
REQ-014 SHALL have port out_valid  output  1: plaintext is valid.
REQ-015 SHALL have port out_ready  input  1: consumer accepts the plaintext.
REQ-016 SHALL have port plaintext  output  PLAINTEXT_WIDTH: decrypted message m.
REQ-017 SHALL have port busy  output  1: high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, LOAD, FINISH and OUT.
REQ-019 In IDLE, start=1 SHALL capture b_in mod q, clear the accumulator and beat counter, and move to LOAD.
REQ-020 In LOAD, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-021 A beat SHALL be accepted only when in_valid && in_ready; each accepted beat SHALL do acc <= (acc + (a_in mod q)*(s_in mod q)) mod q, using a full 2*CIPHERTEXT_WIDTH product before reduction.
REQ-022 On the DIMENSION-th accepted beat, the state SHALL move to FINISH; in_valid gaps SHALL stall the accumulation without corrupting it.
REQ-023 FINISH SHALL last one cycle, computing x = (b - acc) mod q and m = ((x + q/(2p)) >> log2(q/p)) mod p, then register m on plaintext, set out_valid=1, and move to OUT.
REQ-024 In OUT, out_valid and plaintext SHALL hold stable until out_valid && out_ready; on that edge out_valid SHALL go to 0 and the state SHALL return to IDLE.
REQ-025 plaintext SHALL hold its last value after the handshake until the next FINISH.
REQ-026 start SHALL be ignored in every state except IDLE.
REQ-027 Latency: with in_valid held high, out_valid SHALL rise DIMENSION+2 edges after the start-sampling edge, counting that edge as the first.
REQ-028 Wrap-around: a negative b-acc SHALL wrap mod q, and rounding past p-1 SHALL wrap to 0.
REQ-029 Simultaneous in_valid and start while in IDLE: start SHALL be taken and the beat SHALL not be accepted.

Reset
REQ-030 rst_n=1 on a rising edge SHALL force IDLE, and set in_ready=0, out_valid=0, busy=0, plaintext=0, accumulator=0, counter=0.
REQ-031 Reset SHALL override every other input in any state, including mid-LOAD and during OUT; any partial result SHALL be discarded.
REQ-032 The first start after reset is released SHALL decrypt correctly, with no residue from the aborted operation.

Verification (defaults unless noted)
REQ-033 n=1: start with b=458, beat a=0, s=7 -> x=458, plaintext=29, out_valid on the 3rd edge.
REQ-034 n=1: b=102, a=3, s=5 -> x=87, plaintext=5; b=10, a=1, s=14 -> x=1020, plaintext=0 (top wrap); b=10, a=1, s=20 -> x=1014, plaintext=63.
REQ-035 DIMENSION=4: b=1000; beats (100,1), (200,2), (300,3), (400,4) with in_valid low for 2 cycles between beats 2 and 3 -> acc=952, x=48, plaintext=3.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in OUT and pulse start -> out_valid and plaintext stay stable, start is ignored, and the state returns to IDLE one edge after out_ready=1.
REQ-037 Assert rst_n after 1 of 4 beats (DIMENSION=4) -> all outputs are 0 on the next edge; a following full decryption (REQ-035 vector) yields 3.
